// File: rtl/bitwise_pkg.sv
// Op codes and per-bit evaluation shared by the bitwise operation blocks.
// Purely combinational helpers; no state, no handshake.
package bitwise_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND   = 3'd0;
  localparam logic [OP_W-1:0] OP_OR    = 3'd1;
  localparam logic [OP_W-1:0] OP_XOR   = 3'd2;
  localparam logic [OP_W-1:0] OP_NOT_A = 3'd3;
  localparam logic [OP_W-1:0] OP_NAND  = 3'd4;
  localparam logic [OP_W-1:0] OP_NOR   = 3'd5;
  localparam logic [OP_W-1:0] OP_XNOR  = 3'd6;
  localparam logic [OP_W-1:0] OP_ANDN  = 3'd7;

  // Single-bit evaluation; every op is bitwise, so callers replicate it per lane.
  function automatic logic bw_eval(input logic [OP_W-1:0] op, input logic a, input logic b);
    logic r;
    r = 1'b0;
    case (op)
      OP_AND:   r = a & b;
      OP_OR:    r = a | b;
      OP_XOR:   r = a ^ b;
      OP_NOT_A: r = ~a;
      OP_NAND:  r = ~(a & b);
      OP_NOR:   r = ~(a | b);
      OP_XNOR:  r = ~(a ^ b);
      OP_ANDN:  r = a & ~b;
      default:  r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bitwise_func.sv
// Combinational 8-op bitwise decoder, zero latency.
// No handshake; result follows op/a/b in the same cycle.
module bitwise_func
  import bitwise_pkg::*;
#(
  parameter int WIDTH = 7
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] r
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    assign r[i] = bw_eval(op, a[i], b[i]);
  end

endmodule

// File: rtl/bitwise_alu_pipe.sv
// 2-stage bitwise ALU with XOR-accumulate packets; accepted beat -> out_valid 2 cycles later.
// Backpressure: global stall, in_ready = !out_valid || out_ready, no skid buffer.
module bitwise_alu_pipe
  import bitwise_pkg::*;
#(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  input  logic             acc_mode,
  input  logic             last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic             zero,
  output logic             parity
);

  logic             advance;
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [OP_W-1:0]  s1_op;
  logic             s1_acc;
  logic             s1_last;

  logic [WIDTH-1:0] acc;
  logic             acc_active;

  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] acc_fold;
  logic             emit;
  logic [WIDTH-1:0] q_next;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  bitwise_func #(.WIDTH(WIDTH)) u_func (
    .op (s1_op),
    .a  (s1_a),
    .b  (s1_b),
    .r  (r)
  );

  // A packet's first beat seeds the accumulator rather than folding into stale contents.
  always_comb begin
    acc_fold = acc_active ? (acc ^ r) : r;
    emit     = s1_valid && (!s1_acc || s1_last);
    q_next   = q;
    if (emit) begin
      q_next = s1_acc ? acc_fold : r;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_op      <= '0;
      s1_acc     <= 1'b0;
      s1_last    <= 1'b0;
      out_valid  <= 1'b0;
      q          <= '0;
      zero       <= 1'b1;
      parity     <= 1'b0;
      acc        <= '0;
      acc_active <= 1'b0;
    end else if (advance) begin
      s1_valid  <= in_valid;
      s1_a      <= a;
      s1_b      <= b;
      s1_op     <= op;
      s1_acc    <= acc_mode;
      s1_last   <= last;
      out_valid <= emit;
      q         <= q_next;
      zero      <= (q_next == '0);
      parity    <= ^q_next;
      if (s1_valid && s1_acc) begin
        if (s1_last) begin
          acc_active <= 1'b0;
        end else begin
          acc        <= acc_fold;
          acc_active <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bitwise_alu_pipe.sv
// Directed bench for bitwise_alu_pipe at WIDTH=7 with hand-computed expectations.
// Inputs change 1 time unit after posedge; outputs sampled 1 time unit later.
module tb_bitwise_alu_pipe;
  import bitwise_pkg::*;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] a;
  logic [6:0] b;
  logic [2:0] op;
  logic       acc_mode;
  logic       last;
  logic       out_valid;
  logic       out_ready;
  logic [6:0] q;
  logic       zero;
  logic       parity;

  int nchk = 0;
  int nerr = 0;

  bitwise_alu_pipe #(.WIDTH(7)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .acc_mode  (acc_mode),
    .last      (last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .zero      (zero),
    .parity    (parity)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [6:0] da, input logic [6:0] db,
                       input logic [2:0] dop, input logic dacc, input logic dlast);
    in_valid = v;
    a        = da;
    b        = db;
    op       = dop;
    acc_mode = dacc;
    last     = dlast;
  endtask

  task automatic idle();
    drive(1'b0, 7'd0, 7'd0, OP_AND, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [6:0] t2_exp [8] = '{7'b1010000, 7'b1111101, 7'b0101101, 7'b0000111,
                             7'b0101111, 7'b0000010, 7'b1010010, 7'b0101000};
  logic [6:0] t3_a [3] = '{7'b0000001, 7'b0000100, 7'b0010000};
  logic [6:0] t3_b [3] = '{7'b0000010, 7'b0001000, 7'b0100000};
  logic [6:0] t3_e [3] = '{7'b0000011, 7'b0001100, 7'b0110000};

  initial begin
    int         nb;
    int         nout;
    int         stalls;
    logic       was_stall;
    logic [6:0] held;

    rst       = 1'b1;
    out_ready = 1'b1;
    idle();
    tick();
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_q", q, 0);
    chk("rst_zero", zero, 1);
    chk("rst_parity", parity, 0);
    rst = 1'b0;

    // single AND beat, latency check
    drive(1'b1, 7'b1010101, 7'b1100110, OP_AND, 1'b0, 1'b0);
    #1;
    chk("t1_in_ready", in_ready, 1);
    tick();
    idle();
    chk("t1_not_yet", out_valid, 0);
    tick();
    chk("t1_out_valid", out_valid, 1);
    chk("t1_q", q, 7'b1000100);
    chk("t1_zero", zero, 0);
    chk("t1_parity", parity, 0);
    tick();
    chk("t1_drain", out_valid, 0);

    // all eight ops back-to-back
    for (int i = 0; i < 10; i++) begin
      if (i < 8) drive(1'b1, 7'b1111000, 7'b1010101, 3'(i), 1'b0, 1'b0);
      else idle();
      tick();
      if (i >= 1 && i <= 8) begin
        chk("t2_valid", out_valid, 1);
        chk("t2_q", q, t2_exp[i-1]);
      end
    end
    chk("t2_drain", out_valid, 0);

    // stall with three beats offered
    nb = 0; nout = 0; stalls = 0; was_stall = 1'b0; held = '0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      out_ready = (cyc >= 5);
      if (nb < 3) drive(1'b1, t3_a[nb], t3_b[nb], OP_OR, 1'b0, 1'b0);
      else idle();
      #1;
      if (was_stall) chk("t3_hold", q, held);
      if (out_valid && !out_ready) begin
        chk("t3_in_ready_low", in_ready, 0);
        held = q;
        was_stall = 1'b1;
        stalls++;
      end else begin
        was_stall = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (nout < 3) chk("t3_order", q, t3_e[nout]);
        nout++;
      end
      if (in_valid && in_ready) nb++;
      @(posedge clk);
      #1;
    end
    chk("t3_outputs", nout, 3);
    chk("t3_accepted", nb, 3);
    chk("t3_stall_cycles", stalls, 3);
    out_ready = 1'b1;

    // three-beat XOR accumulate packet
    nout = 0;
    for (int i = 0; i < 8; i++) begin
      case (i)
        0: drive(1'b1, 7'b0000001, 7'd0, OP_XOR, 1'b1, 1'b0);
        1: drive(1'b1, 7'b0000010, 7'd0, OP_XOR, 1'b1, 1'b0);
        2: drive(1'b1, 7'b0000100, 7'd0, OP_XOR, 1'b1, 1'b1);
        default: idle();
      endcase
      tick();
      if (out_valid) begin
        nout++;
        chk("t4_q", q, 7'b0000111);
        chk("t4_parity", parity, 1);
      end
    end
    chk("t4_count", nout, 1);

    // reset mid-packet discards partial accumulation
    drive(1'b1, 7'b0001111, 7'd0, OP_XOR, 1'b1, 1'b0);
    tick();
    drive(1'b1, 7'b0110000, 7'd0, OP_XOR, 1'b1, 1'b0);
    tick();
    idle();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_zero", zero, 1);
    drive(1'b1, 7'b0000011, 7'd0, OP_OR, 1'b1, 1'b1);
    tick();
    idle();
    tick();
    chk("t5_valid", out_valid, 1);
    chk("t5_q", q, 7'b0000011);
    tick();

    // XOR of equal operands gives zero
    drive(1'b1, 7'b0110011, 7'b0110011, OP_XOR, 1'b0, 1'b0);
    tick();
    idle();
    tick();
    chk("t6_valid", out_valid, 1);
    chk("t6_q", q, 0);
    chk("t6_zero", zero, 1);
    chk("t6_parity", parity, 0);
    tick();

    // reset while stalled
    out_ready = 1'b0;
    drive(1'b1, 7'b1111111, 7'b1111111, OP_AND, 1'b0, 1'b0);
    tick();
    idle();
    tick();
    chk("t7_valid", out_valid, 1);
    chk("t7_parity", parity, 1);
    tick();
    chk("t7_stalled", out_valid, 1);
    chk("t7_in_ready", in_ready, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t7_rst_valid", out_valid, 0);
    chk("t7_rst_q", q, 0);
    out_ready = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end

endmodule
